// File: rtl/signed_mult_seq_ctrl_pkg.sv
// Shared types and defaults for the signed multiply sequencer.
package signed_mult_pkg;

  localparam int DEF_W       = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_MUL   = 3'd3,
    ST_NEG   = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  // Wait counter must hold every value up to TIMEOUT.
  function automatic int tmo_cw(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEF_TCW = tmo_cw(DEF_TIMEOUT);

endpackage

// File: rtl/signed_mult_seq_ctrl_if.sv
// Select/finish handshake between the multiply sequencer and the complement unit.
interface signed_mult_seq_ctrl_if #(
  parameter int W = 4
);
  logic         cmp_sel;
  logic [W-1:0] cmp_in;
  logic [W-1:0] cmp_out;
  logic         cmp_finish;

  modport master (output cmp_sel, cmp_in, input cmp_out, cmp_finish);
  modport slave  (input cmp_sel, cmp_in, output cmp_out, cmp_finish);
endinterface

// File: rtl/signed_mult_seq_ctrl_shift_add_core.sv
// Unsigned W x W shift-add multiplier: load once, then W steps leave the product in o_acc.
module shift_add_core #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_mcand,
  input  logic [W-1:0]   i_mult,
  output logic [2*W-1:0] o_acc,
  output logic [2*W-1:0] o_acc_next,
  output logic           o_last
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mult;
  logic [CW-1:0]  r_cnt;

  logic [W-1:0]   w_addend;
  logic [W:0]     w_sum;

  // Carry out of the upper-half add lands in the MSB after the shift.
  assign w_addend   = r_mult[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
  assign o_acc_next = {w_sum, r_acc[W-1:1]};
  assign o_acc      = r_acc;
  assign o_last     = (r_cnt == LAST);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_acc   <= '0;
      r_mcand <= i_mcand;
      r_mult  <= i_mult;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_acc   <= o_acc_next;
      r_mult  <= r_mult >> 1;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/signed_mult_seq_ctrl.sv
// Signed W-bit multiply sequencer: takes operand magnitudes via the complement unit,
// runs an unsigned shift-add, and re-applies the sign.
module signed_mult_seq_ctrl
  import signed_mult_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [W-1:0]          i_a,
  input  logic [W-1:0]          i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2*W-1:0]        o_product,
  signed_mult_seq_ctrl_if.master cmp
);

  localparam int             TCW      = tmo_cw(TIMEOUT);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  state_e         r_state;
  state_e         w_next;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sign;
  logic           r_err;
  logic [2*W-1:0] r_product;
  logic [TCW-1:0] r_wait;

  logic           w_abs;
  logic           w_timeout;
  logic           w_load;
  logic           w_step;
  logic           w_last;
  logic [W-1:0]   w_load_mcand;
  logic [W-1:0]   w_load_mult;
  logic [2*W-1:0] w_acc;
  logic [2*W-1:0] w_acc_next;

  assign w_abs     = (r_state == ST_ABS_A) || (r_state == ST_ABS_B);
  assign w_timeout = w_abs && !cmp.cmp_finish && (r_wait == TMO_LAST);
  assign w_load    = (r_state != ST_MUL) && (w_next == ST_MUL);
  assign w_step    = (r_state == ST_MUL);

  assign o_err     = r_err;
  assign o_product = r_product;

  // A magnitude arriving this cycle bypasses its register straight into the core.
  always_comb begin
    w_load_mcand = r_a;
    w_load_mult  = r_b;
    if (r_state == ST_IDLE) begin
      w_load_mcand = i_a;
      w_load_mult  = i_b;
    end else if (r_state == ST_ABS_A) begin
      w_load_mcand = cmp.cmp_out;
    end else if (r_state == ST_ABS_B) begin
      w_load_mult  = cmp.cmp_out;
    end
  end

  shift_add_core #(.W(W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (w_load_mcand),
    .i_mult     (w_load_mult),
    .o_acc      (w_acc),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_a[W-1])      w_next = ST_ABS_A;
          else if (i_b[W-1]) w_next = ST_ABS_B;
          else               w_next = ST_MUL;
        end
      end
      ST_ABS_A: begin
        if (cmp.cmp_finish) w_next = r_b[W-1] ? ST_ABS_B : ST_MUL;
        else if (w_timeout) w_next = ST_FIN;
      end
      ST_ABS_B: begin
        if (cmp.cmp_finish) w_next = ST_MUL;
        else if (w_timeout) w_next = ST_FIN;
      end
      ST_MUL: begin
        if (w_last) w_next = (r_sign && (w_acc_next != '0)) ? ST_NEG : ST_FIN;
      end
      ST_NEG:  w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    cmp.cmp_sel = 1'b0;
    cmp.cmp_in  = '0;
    case (r_state)
      ST_ABS_A: begin
        o_busy      = 1'b1;
        cmp.cmp_sel = 1'b1;
        cmp.cmp_in  = r_a;
      end
      ST_ABS_B: begin
        o_busy      = 1'b1;
        cmp.cmp_sel = 1'b1;
        cmp.cmp_in  = r_b;
      end
      ST_MUL, ST_NEG: o_busy = 1'b1;
      ST_FIN:         o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_err     <= 1'b0;
      r_product <= '0;
      r_wait    <= '0;
    end else begin
      if (w_next != r_state) r_wait <= '0;
      else if (w_abs)        r_wait <= r_wait + TCW'(1);

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_sign    <= i_a[W-1] ^ i_b[W-1];
            r_err     <= 1'b0;
            r_product <= '0;
          end
        end
        ST_ABS_A: begin
          if (cmp.cmp_finish) r_a <= cmp.cmp_out;
          else if (w_timeout) begin
            r_err     <= 1'b1;
            r_product <= '0;
          end
        end
        ST_ABS_B: begin
          if (cmp.cmp_finish) r_b <= cmp.cmp_out;
          else if (w_timeout) begin
            r_err     <= 1'b1;
            r_product <= '0;
          end
        end
        ST_MUL: begin
          if (w_last && (w_next == ST_FIN)) r_product <= w_acc_next;
        end
        ST_NEG:  r_product <= ~w_acc + (2*W)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mult_seq_ctrl.sv
// Directed bench for signed_mult_seq_ctrl with a behavioural complement unit.
module tb_signed_mult_seq_ctrl;

  localparam int W   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] product;

  signed_mult_seq_ctrl_if #(.W(W)) cmp_bus ();

  signed_mult_seq_ctrl #(.W(W), .TIMEOUT(TMO)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_product (product),
    .cmp       (cmp_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Complement unit: answers -cmp_in after cmp_lat cycles of cmp_sel, unless disabled.
  int           cmp_lat = 2;
  bit           cmp_en  = 1'b1;
  int           req_cnt = 0;
  int           sel_cycles = 0;
  int           unstable_cnt = 0;
  int           hold_cnt = 0;
  logic [W-1:0] req_in [16];

  always @(negedge clk) begin
    if (!rst) begin
      cmp_bus.cmp_finish = 1'b0;
      cmp_bus.cmp_out    = '0;
      hold_cnt           = 0;
    end else begin
      if (cmp_bus.cmp_finish) begin
        cmp_bus.cmp_finish = 1'b0;
        hold_cnt           = 0;
      end
      if (cmp_bus.cmp_sel) begin
        sel_cycles++;
        if (hold_cnt == 0) begin
          req_in[req_cnt % 16] = cmp_bus.cmp_in;
          req_cnt++;
        end else if (cmp_bus.cmp_in !== req_in[(req_cnt - 1) % 16]) begin
          unstable_cnt++;
        end
        hold_cnt++;
        if (cmp_en && hold_cnt == cmp_lat) begin
          cmp_bus.cmp_finish = 1'b1;
          cmp_bus.cmp_out    = -cmp_bus.cmp_in;
        end
      end else begin
        hold_cnt = 0;
      end
    end
  end

  // Issues one operation from IDLE (called on a falling edge) and checks the whole transaction.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit noise,
                        input logic [2*W-1:0] exp_p, input logic exp_err, input int exp_lat,
                        input int exp_sel, input int exp_reqs,
                        input logic [W-1:0] exp_in0, input logic [W-1:0] exp_in1,
                        input string tag);
    int base_req;
    int base_sel;
    int base_uns;
    int n;
    bit seen;
    base_req = req_cnt;
    base_sel = sel_cycles;
    base_uns = unstable_cnt;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    check({tag, "_busy_after_start"}, busy, 1);
    n    = 1;
    seen = 1'b0;
    while (n < 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (noise && (n == 2 || n == 4)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_cmp_sel_at_done"}, cmp_bus.cmp_sel, 0);
    check({tag, "_sel_cycles"}, sel_cycles - base_sel, exp_sel);
    check({tag, "_requests"}, req_cnt - base_req, exp_reqs);
    check({tag, "_cmp_in_stable"}, unstable_cnt - base_uns, 0);
    if (exp_reqs >= 1) check({tag, "_cmp_in0"}, req_in[base_req % 16], exp_in0);
    if (exp_reqs >= 2) check({tag, "_cmp_in1"}, req_in[(base_req + 1) % 16], exp_in1);
    // start during FIN must be ignored
    start = 1'b1;
    a     = 4'h5;
    b     = 4'h5;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_fin_start_ignored"}, busy, 0);
    check({tag, "_product_held"}, product, exp_p);
    check({tag, "_err_held"}, err, exp_err);
    @(negedge clk);
    check({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_product", product, 0);
    check("rst_cmp_sel", cmp_bus.cmp_sel, 0);
    check("rst_cmp_in", cmp_bus.cmp_in, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(4'h3, 4'h2, 1'b0, 8'h06, 1'b0, 5, 0, 0, 4'h0, 4'h0, "t1_pos_pos");
    run_op(4'hD, 4'h2, 1'b0, 8'hFA, 1'b0, 8, 2, 1, 4'hD, 4'h0, "t2_neg_pos");
    run_op(4'h8, 4'h8, 1'b0, 8'h40, 1'b0, 9, 4, 2, 4'h8, 4'h8, "t3_min_min");
    run_op(4'h0, 4'hB, 1'b0, 8'h00, 1'b0, 7, 2, 1, 4'hB, 4'h0, "t4_zero_neg");

    cmp_en = 1'b0;
    run_op(4'hF, 4'h1, 1'b0, 8'h00, 1'b1, 9, TMO, 1, 4'hF, 4'h0, "t5_timeout");
    cmp_en = 1'b1;

    // Reset during the second MUL cycle
    a     = 4'h7;
    b     = 4'h7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t6_busy_mul1", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_product", product, 0);
    check("t6_rst_cmp_sel", cmp_bus.cmp_sel, 0);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_idle_after_rst", busy, 0);
    check("t6_no_done_after_rst", done, 0);

    run_op(4'h7, 4'h9, 1'b1, 8'hCF, 1'b0, 8, 2, 1, 4'h9, 4'h0, "t6_pos_neg_noise");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/signed_mult_seq_ctrl.md
Name: signed_mult_seq_ctrl

Overview:
Sequencer for the 4-bit signed multiply path of the calculator. It latches two signed operands on a start pulse and uses the shared complement unit, through a select/finish handshake, to take the magnitude of each negative operand. It then runs a W-cycle unsigned shift-add and negates the product when the operand signs differ. It sits between the calculator top-level control and the complement unit and owns all of that unit's request traffic.

Parameters:
W, 4, operand width in bits; product is 2W bits.
TIMEOUT, 16, max cycles to wait for cmp_finish per request before aborting with err.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE.
a  input  W  signed multiplicand, captured on accepted start.
b  input  W  signed multiplier, captured on accepted start.
busy  output  1  high from the cycle after accepted start until done.
done  output  1  one-cycle pulse when product/err are valid.
err  output  1  complement-unit timeout flag, valid with done, held until next start.
product  output  2W  signed two's-complement product, held until next accepted start.
cmp_sel  output  1  request to complement unit; held high until cmp_finish sampled.
cmp_in  output  W  operand to complement unit; stable while cmp_sel high.
cmp_out  input  W  complement-unit result (negation of cmp_in), valid when cmp_finish high.
cmp_finish  input  1  complement-unit completion.

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, err=0, product=0, cmp_sel=0, cmp_in=0; internal regs cleared. Applies mid-operation; an in-flight cmp request is dropped; cmp_finish ignored after reset.
- States: IDLE, ABS_A, ABS_B, MUL, NEG, FIN.
- IDLE: start=1 -> capture a,b; sign_r = a[W-1]^b[W-1]; busy=1; err=0. Next state ABS_A if a negative, else ABS_B if b negative, else MUL.
- ABS_x: cmp_sel=1, cmp_in=operand. On cmp_finish=1, register cmp_out as the unsigned magnitude (a = -2^(W-1) yields magnitude 2^(W-1), treated unsigned). Deassert cmp_sel the following cycle. ABS_A goes to ABS_B if b is negative, else MUL.
- Timeout: wait counter reset on entering ABS_x. Reaching TIMEOUT cycles without cmp_finish -> cmp_sel=0, err=1, product=0, go to FIN.
- MUL: exactly W cycles. Each cycle: if mult LSB is 1, add mcand to upper half of the 2W accumulator (W+1-bit add incl. carry); then shift right by 1. No overflow possible (|product| <= 2^(2W-2)).
- NEG: entered after MUL only if sign_r=1 and magnitude != 0. Product = ~acc + 1 (2W bits). 1 cycle. Otherwise MUL goes straight to FIN.
- FIN: product register valid; done=1 for exactly one cycle; busy=0 on the same cycle; next state IDLE.
- Latency with both operands non-negative: start sampled at cycle 0, MUL at cycles 1..W, done at cycle W+1. Each negative operand adds (cmp latency + 1). A NEG step adds 1 cycle.
- start while busy: ignored, with no effect on a/b capture. start in the FIN cycle: ignored. Back-to-back requests are accepted from IDLE one cycle after done.
- cmp_finish outside ABS_x: ignored.

Decomposition:
- Package signed_mult_pkg: state enum (6 states, 3-bit encoding), default W, and TIMEOUT counter width = $clog2(TIMEOUT+1).
- One sub-module, shift_add_core: holds the accumulator and multiplier regs and the iteration counter; interface load/step/acc. The FSM, handshake, timeout and negation stay in the controller.

Test Plan:
1. a=3, b=2, start 1 cycle -> cmp_sel never high; done at cycle 5; product=0x06; err=0.
2. a=-3 (4'hD), b=2; cmp model returns 4'h3 after 2 cycles -> cmp_in=4'hD while cmp_sel high; product=0xFA (-6); err=0.
3. a=-8, b=-8 -> two cmp requests (cmp_in 4'h8 each, cmp_out 4'h8); no NEG; product=0x40 (64).
4. a=0, b=-5 -> one cmp request for b; sign differs but magnitude 0 so NEG skipped; product=0x00.
5. a=-1, b=1, cmp model never asserts finish, TIMEOUT=8 -> cmp_sel high 8 cycles then low; done pulse; err=1, product=0.
6. a=7, b=7; assert rst=0 in the 2nd MUL cycle -> all outputs 0 immediately. After release, start with a=7, b=-7 -> product=0xCF (-49). start pulses while busy are ignored and do not alter the result.
